// File: rtl/btn_event_arbiter.sv
// Synchronizes, debounces and edge-detects WIDTH buttons, then serves press events round-robin
// on a valid/ready port. Define BTN_RELEASE_EVT_EN to also queue release events (adds evt_release).
module btn_event_arbiter #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [WIDTH-1:0]                          btn_async,
  output logic [WIDTH-1:0]                          btn_level,
  output logic                                      evt_valid,
  input  logic                                      evt_ready,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] evt_id,
  output logic                                      evt_overrun
`ifdef BTN_RELEASE_EVT_EN
  ,
  output logic                                      evt_release
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef BTN_RELEASE_EVT_EN
  localparam int NS = 2 * WIDTH;
`else
  localparam int NS = WIDTH;
`endif
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = $clog2(SAMPLE_CNT_MAX);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(PULSE_CNT_MAX);
  localparam logic [SW-1:0] SRC_LAST  = SW'(NS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [WIDTH-1:0]          sync1_q, sync2_q;
  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic                      tick_s;
  logic [WIDTH-1:0][CW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [WIDTH-1:0]          btn_level_q, btn_level_d, level_prev_q;
  logic [WIDTH-1:0]          press_s;
`ifdef BTN_RELEASE_EVT_EN
  logic [WIDTH-1:0]          release_s;
  logic                      evt_release_q, evt_release_d;
`endif
  logic [NS-1:0]             src_evt_s, clr_mask_s, pend_q, pend_d;
  logic                      evt_overrun_q, evt_overrun_d;
  logic                      accept_s;
  logic                      hi_found_s, lo_found_s;
  logic [SW-1:0]             hi_idx_s, lo_idx_s, gnt_idx_s;
  state_t                    state_q, state_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [SW-1:0]             src_q, src_d, last_q, last_d;
  logic [IW-1:0]             evt_id_q, evt_id_d;

  // Sample-tick counter shared by every debouncer
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Per-button saturating debounce; level follows the next counter value so release lags sync by one cycle
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    btn_level_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!sync2_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (tick_s && (deb_cnt_q[i] != CNT_MAX)) begin
        deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i];
      end
      btn_level_d[i] = (deb_cnt_d[i] == CNT_MAX);
    end
  end

  // Synchronizers, tick counter, debounce counters and level history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      tick_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      btn_level_q  <= '0;
      level_prev_q <= '0;
    end else begin
      sync1_q      <= btn_async;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      btn_level_q  <= btn_level_d;
      level_prev_q <= btn_level_q;
    end
  end

  // Edge detection, pending set/clear and overrun; a re-press of the source being accepted is kept as new
  always_comb begin
    press_s   = btn_level_q & ~level_prev_q;
    src_evt_s = '0;
`ifdef BTN_RELEASE_EVT_EN
    release_s = ~btn_level_q & level_prev_q;
    for (int i = 0; i < WIDTH; i++) begin
      src_evt_s[2*i]   = press_s[i];
      src_evt_s[2*i+1] = release_s[i];
    end
`else
    src_evt_s = press_s;
`endif
    accept_s   = (state_q == HOLD) && evt_valid_q && evt_ready;
    clr_mask_s = '0;
    if (accept_s) begin
      clr_mask_s[src_q] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    pend_d        = (pend_q & ~clr_mask_s) | src_evt_s;
    evt_overrun_d = |(src_evt_s & pend_q & ~clr_mask_s);
  end

  // Pending flags and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      evt_overrun_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  // Round-robin pick: lowest pending index above last_q, else lowest pending index overall
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (pend_q[i] && (SW'(i) > last_q)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = SW'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
      if (pend_q[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = SW'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    if (hi_found_s) begin
      gnt_idx_s = hi_idx_s;
    end else begin
      gnt_idx_s = lo_idx_s;
    end
  end

  // Grant/hold FSM next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    src_d       = src_q;
    last_d      = last_q;
    evt_id_d    = evt_id_q;
`ifdef BTN_RELEASE_EVT_EN
    evt_release_d = evt_release_q;
`endif
    case (state_q)
      IDLE: begin
        if (lo_found_s) begin
          state_d     = HOLD;
          evt_valid_d = 1'b1;
          src_d       = gnt_idx_s;
`ifdef BTN_RELEASE_EVT_EN
          evt_id_d      = IW'(gnt_idx_s >> 1);
          evt_release_d = gnt_idx_s[0];
`else
          evt_id_d    = gnt_idx_s;
`endif
        end else begin
          state_d     = IDLE;
          evt_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (accept_s) begin
          state_d     = IDLE;
          evt_valid_d = 1'b0;
          last_d      = src_q;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and event-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      src_q       <= '0;
      last_q      <= SRC_LAST;
      evt_id_q    <= '0;
`ifdef BTN_RELEASE_EVT_EN
      evt_release_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      src_q       <= src_d;
      last_q      <= last_d;
      evt_id_q    <= evt_id_d;
`ifdef BTN_RELEASE_EVT_EN
      evt_release_q <= evt_release_d;
`endif
    end
  end

  assign btn_level   = btn_level_q;
  assign evt_valid   = evt_valid_q;
  assign evt_id      = evt_id_q;
  assign evt_overrun = evt_overrun_q;
`ifdef BTN_RELEASE_EVT_EN
  assign evt_release = evt_release_q;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter: a reference model predicts levels, grants and overruns;
// a negedge monitor compares the DUT against it and pops expected event ids on each handshake.
module tb_btn_event_arbiter;
  localparam int W  = 4;
  localparam int SM = 4;
  localparam int PM = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] btn_async = '0;
  logic         evt_ready = 1'b0;
  logic [W-1:0] btn_level;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_overrun;
`ifdef BTN_RELEASE_EVT_EN
  logic         evt_release;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int ovr_cnt = 0;

  // reference model state (values as they stand after the most recent clock edge)
  int           k_edge;
  int           rs_a[W], rs_b[W], rs_c[W];
  logic [W-1:0] lvl_cur, lvl_prev, pend;
  bit           offered, exp_ovr;
  int           off_id, last_id;
  int           exp_q[$];

  always #4 clk = ~clk;

  btn_event_arbiter #(.WIDTH(W), .SAMPLE_CNT_MAX(SM), .PULSE_CNT_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .btn_async(btn_async), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
`ifdef BTN_RELEASE_EVT_EN
    .evt_release(evt_release),
`endif
    .evt_overrun(evt_overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a level is declared once the synced input has stayed high across PM sample ticks.
  // Input sampled at edge j reaches the debouncer at edge j+2; ticks fall on edges that are multiples of SM.
  initial begin : model
    logic [W-1:0] lvl_new, press, clr, npend;
    int a, n, c;
    bit acc, got;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k_edge = 0;
        for (int i = 0; i < W; i++) begin
          rs_a[i] = 0; rs_b[i] = 0; rs_c[i] = 0;
        end
        lvl_cur = '0; lvl_prev = '0; pend = '0;
        offered = 1'b0; exp_ovr = 1'b0; off_id = 0; last_id = W - 1;
        exp_q.delete();
      end else begin
        k_edge++;
        for (int i = 0; i < W; i++) begin
          rs_c[i] = rs_b[i];
          rs_b[i] = rs_a[i];
          rs_a[i] = btn_async[i] ? ((rs_b[i] != 0) ? rs_b[i] : k_edge) : 0;
          lvl_new[i] = 1'b0;
          if (rs_c[i] != 0) begin
            a = rs_c[i] + 2;
            n = k_edge / SM - (a - 1) / SM;
            lvl_new[i] = (n >= PM);
          end
        end
        press    = lvl_cur & ~lvl_prev;
        lvl_prev = lvl_cur;
        lvl_cur  = lvl_new;
        acc      = offered && evt_ready;
        clr      = acc ? (W'(1) << off_id) : '0;
        exp_ovr  = |(press & pend & ~clr);
        npend    = (pend & ~clr) | press;
        if (offered) begin
          if (acc) begin
            offered = 1'b0;
            last_id = off_id;
          end
        end else begin
          got = 1'b0;
          for (int s = 1; s <= W; s++) begin
            c = (last_id + s) % W;
            if (!got && pend[c]) begin
              got = 1'b1;
              off_id = c;
            end
          end
          if (got) begin
            offered = 1'b1;
            exp_q.push_back(off_id);
          end
        end
        pend = npend;
      end
    end
  end

  // Monitor: compares the DUT each negedge and consumes one expected event per handshake
  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("btn_level", int'(btn_level), int'(lvl_cur));
        check("evt_valid", int'(evt_valid), int'(offered));
        check("evt_overrun", int'(evt_overrun), int'(exp_ovr));
        if (evt_overrun) ovr_cnt++;
        if (evt_valid) begin
          check("event_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            check("evt_id", int'(evt_id), exp_q[0]);
            if (evt_ready) begin
              e = exp_q.pop_front();
              acc_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int base, ovb, rem[W];
    bit got;
    rst_n = 1'b0; btn_async = 4'hF; evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_btn_level", int'(btn_level), 0);
    check("rst_evt_valid", int'(evt_valid), 0);
    check("rst_evt_overrun", int'(evt_overrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(16);
    check("level_after_reset", int'(btn_level), 15);
    step(44);
    check("reset_event_count", acc_cnt, 4);

    btn_async = '0; step(30);
    base = acc_cnt;
    btn_async[1] = 1'b1; step(6); btn_async[1] = 1'b0; step(30);
    check("glitch_no_event", acc_cnt - base, 0);
    base = acc_cnt;
    btn_async[1] = 1'b1; step(20); btn_async[1] = 1'b0; step(30);
    check("hold_one_event", acc_cnt - base, 1);

    evt_ready = 1'b0; base = acc_cnt;
    btn_async[2] = 1'b1; step(30); btn_async[2] = 1'b0; step(10);
    check("backpressure_held", acc_cnt - base, 0);
    evt_ready = 1'b1; step(20);
    check("backpressure_one_event", acc_cnt - base, 1);

    evt_ready = 1'b0; base = acc_cnt; ovb = ovr_cnt;
    btn_async[0] = 1'b1; step(20); btn_async[0] = 1'b0; step(5);
    btn_async[0] = 1'b1; step(20); btn_async[0] = 1'b0; step(10);
    check("overrun_pulses", ovr_cnt - ovb, 1);
    evt_ready = 1'b1; step(20);
    check("overrun_one_event", acc_cnt - base, 1);

    rst_n = 1'b0; btn_async = 4'h5; step(3);
    rst_n = 1'b1; base = acc_cnt; step(60);
    check("simultaneous_events", acc_cnt - base, 2);

    evt_ready = 1'b0; btn_async = '0; step(20);
    btn_async[3] = 1'b1; got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      step(1);
      if (evt_valid) got = 1'b1;
    end
    check("hold_reached", int'(got), 1);
    rst_n = 1'b0; #1;
    check("async_clear_valid", int'(evt_valid), 0);
    check("async_clear_level", int'(btn_level), 0);
    btn_async[3] = 1'b0; step(2);
    rst_n = 1'b1; evt_ready = 1'b1; base = acc_cnt; step(40);
    check("no_event_after_reset", acc_cnt - base, 0);

    for (int i = 0; i < W; i++) rem[i] = $urandom_range(1, 40);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < W; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          btn_async[i] = ~btn_async[i];
          rem[i] = $urandom_range(1, 40);
        end
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    btn_async = '0; evt_ready = 1'b1; step(100);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
